// File: rtl/ex_16or8_to_32_pkg.sv
// Shared widths and selector encoding for the halfword/byte load extender.
package ex_pkg;

    typedef enum logic {
        SEL_HALF = 1'b0,
        SEL_BYTE = 1'b1
    } sel_e;

    localparam int unsigned HALF_W = 16;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;

endpackage

// File: rtl/ex_16or8_to_32_sign_extend.sv
// Generic combinational extender: widens IN_W bits to OUT_W bits, sign or zero fill.
module sign_extend #(
    parameter int unsigned IN_W     = 16,
    parameter int unsigned OUT_W    = 32,
    parameter bit          SIGN_EXT = 1'b1
) (
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] dout
);

    generate
        if (OUT_W > IN_W) begin : g_widen
            logic fill;
            assign fill = SIGN_EXT ? din[IN_W-1] : 1'b0;
            assign dout = {{(OUT_W-IN_W){fill}}, din};
        end else begin : g_pass
            assign dout = din[OUT_W-1:0];
        end
    endgenerate

endmodule

// File: rtl/ex_16or8_to_32.sv
// Load-path extender: selects halfword or byte operand, extends it, registers the result.
module ex_16or8_to_32
    import ex_pkg::*;
#(
    parameter bit          SIGN_EXT = 1'b1,
    parameter int unsigned OUT_W    = WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              seletor,
    input  logic [HALF_W-1:0] I1,
    input  logic [BYTE_W-1:0] I2,
    output logic [OUT_W-1:0]  F
);

    logic [OUT_W-1:0] ext_half;
    logic [OUT_W-1:0] ext_byte;
    logic [OUT_W-1:0] ext;

    sign_extend #(
        .IN_W     (HALF_W),
        .OUT_W    (OUT_W),
        .SIGN_EXT (SIGN_EXT)
    ) u_ext_half (
        .din  (I1),
        .dout (ext_half)
    );

    sign_extend #(
        .IN_W     (BYTE_W),
        .OUT_W    (OUT_W),
        .SIGN_EXT (SIGN_EXT)
    ) u_ext_byte (
        .din  (I2),
        .dout (ext_byte)
    );

    // An unknown select falls through to the halfword path instead of producing X.
    always_comb begin
        ext = ext_half;
        if (seletor == SEL_BYTE) begin
            ext = ext_byte;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            F <= '0;
        end else begin
            F <= ext;
        end
    end

endmodule

// File: tb/tb_ex_16or8_to_32.sv
// Directed scoreboard bench for ex_16or8_to_32, sign- and zero-extend variants side by side.
module tb_ex_16or8_to_32;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        seletor = 1'b0;
    logic [15:0] I1 = '0;
    logic [7:0]  I2 = '0;
    logic [31:0] F_s;
    logic [31:0] F_z;

    int checks = 0;
    int failures = 0;

    logic [31:0] q_s[$];
    logic [31:0] q_z[$];

    always #5 clk = ~clk;

    ex_16or8_to_32 #(.SIGN_EXT(1'b1), .OUT_W(32)) dut_s (
        .clk(clk), .reset(reset), .seletor(seletor), .I1(I1), .I2(I2), .F(F_s)
    );

    ex_16or8_to_32 #(.SIGN_EXT(1'b0), .OUT_W(32)) dut_z (
        .clk(clk), .reset(reset), .seletor(seletor), .I1(I1), .I2(I2), .F(F_z)
    );

    function automatic logic [31:0] model(input logic sel, input logic [15:0] h,
                                          input logic [7:0] b, input bit sgn);
        logic signed [31:0] t;
        if (sel === 1'b1) begin
            if (sgn) begin
                t = $signed(b);
                return t;
            end
            return {24'd0, b};
        end
        if (sgn) begin
            t = $signed(h);
            return t;
        end
        return {16'd0, h};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive on the falling edge, record expectations, compare just after the rising edge.
    task automatic step(input string tag, input logic sel, input logic [15:0] h,
                        input logic [7:0] b);
        logic [31:0] es;
        logic [31:0] ez;
        @(negedge clk);
        seletor = sel;
        I1 = h;
        I2 = b;
        q_s.push_back(model(sel, h, b, 1'b1));
        q_z.push_back(model(sel, h, b, 1'b0));
        @(posedge clk);
        #1;
        if (q_s.size() == 0 || q_z.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            es = q_s.pop_front();
            ez = q_z.pop_front();
            check({tag, "_sign"}, F_s, es);
            check({tag, "_zero"}, F_z, ez);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Asynchronous reset before any clock edge, inputs random.
        seletor = 1'($urandom);
        I1 = 16'($urandom);
        I2 = 8'($urandom);
        #1 reset = 1'b1;
        #1;
        check("rst_async_s", F_s, 32'd0);
        check("rst_async_z", F_z, 32'd0);
        @(posedge clk);
        #1;
        check("rst_hold_s", F_s, 32'd0);
        check("rst_hold_z", F_z, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        step("first_after_rst", 1'b0, 16'h1234, 8'hA5);
        step("half_pos4", 1'b0, 16'd4, 8'h00);
        step("half_neg4", 1'b0, 16'hFFFC, 8'h00);
        step("byte_pos5", 1'b1, 16'h0000, 8'd5);
        step("byte_neg5", 1'b1, 16'h0000, 8'hFB);
        step("half_8000", 1'b0, 16'h8000, 8'h00);
        step("half_7fff", 1'b0, 16'h7FFF, 8'h00);
        step("byte_80", 1'b1, 16'h0000, 8'h80);
        step("byte_7f", 1'b1, 16'h0000, 8'h7F);

        // Unused-input isolation.
        step("iso_byte_i1_0", 1'b1, 16'h0000, 8'h9C);
        step("iso_byte_i1_1", 1'b1, 16'hFFFF, 8'h9C);
        step("iso_byte_i1_5", 1'b1, 16'h5555, 8'h9C);
        step("iso_half_i2_0", 1'b0, 16'hC3A5, 8'h00);
        step("iso_half_i2_1", 1'b0, 16'hC3A5, 8'hFF);
        step("iso_half_i2_a", 1'b0, 16'hC3A5, 8'hAA);

        // Unknown select takes the halfword path.
        step("sel_x", 1'bx, 16'h8001, 8'h7E);

        // Reset pulse mid-stream: half a cycle, between rising and falling edges.
        step("pre_mid_rst", 1'b1, 16'h0000, 8'hF0);
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst_s", F_s, 32'd0);
        check("mid_rst_z", F_z, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_rel_s", F_s, 32'd0);
        check("mid_rst_rel_z", F_z, 32'd0);
        step("resume", 1'b0, 16'hBEEF, 8'h11);
        step("resume_byte", 1'b1, 16'hBEEF, 8'hC1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
